// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF core: FSM states,
// ring seed pattern and counter width.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_COUNT,
    ST_CMP,
    ST_DONE
  } ro_state_e;

  localparam int RO_MAX_STAGES = 64;

  // Alternating 1010...1 pattern starting with bit0=1; odd lengths end in 1.
  function automatic logic [RO_MAX_STAGES-1:0] ro_seed(input int stages);
    logic [RO_MAX_STAGES-1:0] s;
    s = '0;
    for (int i = 0; i < RO_MAX_STAGES; i++) begin
      if (i < stages) s[i] = ((i % 2) == 0);
    end
    return s;
  endfunction

  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/ro_puf_core_if.sv
// Challenge/response bundle of the PUF core. Optional count outputs exist
// only when RO_PUF_COUNT_OUT_EN is defined.
interface ro_puf_core_if #(
  parameter int NUM_RO = 16,
  parameter int WINDOW = 4096
);
  import ro_puf_pkg::*;

  localparam int SEL_W = $clog2(NUM_RO);
  localparam int CNT_W = cnt_w(WINDOW);

  logic             start;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             busy;
  logic             resp_valid;
  logic             resp;
  logic             tie;
`ifdef RO_PUF_COUNT_OUT_EN
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;

  modport master (output start, sel_a, sel_b,
                  input  busy, resp_valid, resp, tie, count_a, count_b);
  modport slave  (input  start, sel_a, sel_b,
                  output busy, resp_valid, resp, tie, count_a, count_b);
`else
  modport master (output start, sel_a, sel_b,
                  input  busy, resp_valid, resp, tie);
  modport slave  (input  start, sel_a, sel_b,
                  output busy, resp_valid, resp, tie);
`endif

endinterface

// File: rtl/ro_emul.sv
// Emulated ring oscillator: STAGES-bit inverting ring advanced by a private
// divide-by-DIV tick; held at seed with the divider cleared while disabled.
module ro_emul
  import ro_puf_pkg::*;
#(
  parameter int STAGES = 13,
  parameter int DIV    = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic out
);

  localparam logic [STAGES-1:0] SEED = STAGES'(ro_seed(STAGES));
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [STAGES-1:0] s_q, s_d;
  logic [DW-1:0]     div_q, div_d;
  logic              tick;

  always_comb begin
    s_d   = s_q;
    div_d = div_q;
    tick  = (div_q == DW'(DIV - 1));
    if (!en) begin
      s_d   = SEED;
      div_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      // One ring stage toggles per tick, so the output flips every STAGES ticks.
      if (tick) s_d = {~s_q[STAGES-2:0], ~(en & s_q[STAGES-1])};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= SEED;
      div_q <= '0;
    end else begin
      s_q   <= s_d;
      div_q <= div_d;
    end
  end

  assign out = s_q[STAGES-1];

endmodule

// File: rtl/ro_puf_core.sv
// Ring-oscillator PUF core: oscillator bank, challenge FSM, edge counters and
// compare. Define RO_PUF_COUNT_OUT_EN to expose the final counts.
module ro_puf_core
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO   = 16,
  parameter int STAGES   = 13,
  parameter int DIV_BASE = 10,
  parameter int DIV_STEP = 1,
  parameter int WINDOW   = 4096
) (
  input  logic           clk,
  input  logic           rst_n,
  ro_puf_core_if.slave   bus
);

  localparam int SEL_W = $clog2(NUM_RO);
  localparam int CNT_W = cnt_w(WINDOW);

  ro_state_e        state_q, state_d;
  logic [SEL_W-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic             out_a_d_q, out_a_d_d, out_b_d_q, out_b_d_d;
  logic             resp_q, resp_d, tie_q, tie_d;
`ifdef RO_PUF_COUNT_OUT_EN
  logic [CNT_W-1:0] count_a_q, count_a_d, count_b_q, count_b_d;
`endif

  logic [NUM_RO-1:0] ro_en, ro_out;
  logic              out_a, out_b;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    if ({1'b0, s} >= (SEL_W+1)'(NUM_RO)) return SEL_W'(NUM_RO - 1);
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
    ro_emul #(
      .STAGES (STAGES),
      .DIV    (DIV_BASE + i * DIV_STEP)
    ) u_ro (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ro_en[i]),
      .out   (ro_out[i])
    );
  end

  // Only the challenged pair runs, and only during the count window.
  always_comb begin
    ro_en = '0;
    if (state_q == ST_COUNT) begin
      ro_en[sel_a_q] = 1'b1;
      ro_en[sel_b_q] = 1'b1;
    end
  end

  assign out_a = ro_out[sel_a_q];
  assign out_b = ro_out[sel_b_q];

  always_comb begin
    state_d   = state_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    wcnt_d    = wcnt_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    out_a_d_d = out_a_d_q;
    out_b_d_d = out_b_d_q;
    resp_d    = resp_q;
    tie_d     = tie_q;
`ifdef RO_PUF_COUNT_OUT_EN
    count_a_d = count_a_q;
    count_b_d = count_b_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sel_a_d = clamp_sel(bus.sel_a);
          sel_b_d = clamp_sel(bus.sel_b);
          resp_d  = 1'b0;
          tie_d   = 1'b0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        wcnt_d    = '0;
        cnt_a_d   = '0;
        cnt_b_d   = '0;
        out_a_d_d = 1'b0;
        out_b_d_d = 1'b0;
`ifdef RO_PUF_COUNT_OUT_EN
        count_a_d = '0;
        count_b_d = '0;
`endif
        state_d   = ST_COUNT;
      end
      ST_COUNT: begin
        if (out_a && !out_a_d_q) cnt_a_d = sat_inc(cnt_a_q);
        if (out_b && !out_b_d_q) cnt_b_d = sat_inc(cnt_b_q);
        out_a_d_d = out_a;
        out_b_d_d = out_b;
        wcnt_d    = wcnt_q + 1'b1;
        if (wcnt_q == CNT_W'(WINDOW - 1)) state_d = ST_CMP;
      end
      ST_CMP: begin
        resp_d  = (cnt_a_q > cnt_b_q);
        tie_d   = (cnt_a_q == cnt_b_q);
`ifdef RO_PUF_COUNT_OUT_EN
        count_a_d = cnt_a_q;
        count_b_d = cnt_b_q;
`endif
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      wcnt_q    <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      out_a_d_q <= 1'b0;
      out_b_d_q <= 1'b0;
      resp_q    <= 1'b0;
      tie_q     <= 1'b0;
`ifdef RO_PUF_COUNT_OUT_EN
      count_a_q <= '0;
      count_b_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      wcnt_q    <= wcnt_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      out_a_d_q <= out_a_d_d;
      out_b_d_q <= out_b_d_d;
      resp_q    <= resp_d;
      tie_q     <= tie_d;
`ifdef RO_PUF_COUNT_OUT_EN
      count_a_q <= count_a_d;
      count_b_q <= count_b_d;
`endif
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.resp_valid = (state_q == ST_DONE);
  assign bus.resp       = resp_q;
  assign bus.tie        = tie_q;
`ifdef RO_PUF_COUNT_OUT_EN
  assign bus.count_a    = count_a_q;
  assign bus.count_b    = count_b_q;
`endif

endmodule

// File: tb/tb_ro_puf_core.sv
// Self-checking bench for ro_puf_core against a cycle-count model of ideal
// ring-oscillator waveforms.
module tb_ro_puf_core;

  localparam int NUM_RO   = 16;
  localparam int STAGES   = 13;
  localparam int DIV_BASE = 10;
  localparam int DIV_STEP = 1;
  localparam int WINDOW   = 4096;
  localparam int SEL_W    = $clog2(NUM_RO);
  localparam int CNT_W    = $clog2(WINDOW + 1);
  localparam int LAT      = WINDOW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  int   r_lat, r_nvalid;
  logic r_busy1, r_resp, r_tie, r_resp_end, r_tie_end, r_busy_end;
  int   r_ca, r_cb;
  int   saved_ca, saved_cb;

  ro_puf_core_if #(.NUM_RO(NUM_RO), .WINDOW(WINDOW)) bus();

  ro_puf_core #(
    .NUM_RO   (NUM_RO),
    .STAGES   (STAGES),
    .DIV_BASE (DIV_BASE),
    .DIV_STEP (DIV_STEP),
    .WINDOW   (WINDOW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Output of oscillator with divider div after c enabled cycles is high for
  // the first STAGES ticks of each 2*STAGES-tick period; rising edges are
  // counted with the edge register starting at 0.
  function automatic int exp_count(input int sel);
    int div, cnt;
    bit o, od;
    if (sel > NUM_RO - 1) sel = NUM_RO - 1;
    div = DIV_BASE + sel * DIV_STEP;
    cnt = 0;
    od  = 1'b0;
    for (int c = 0; c < WINDOW; c++) begin
      o = (((c / div) / STAGES) % 2) == 0;
      if (o && !od && cnt < (1 << CNT_W) - 1) cnt++;
      od = o;
    end
    return cnt;
  endfunction

  task automatic launch(input int a, input int b);
    @(negedge clk);
    bus.sel_a = SEL_W'(a);
    bus.sel_b = SEL_W'(b);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic observe(input int repulse_k);
    r_lat    = -1;
    r_nvalid = 0;
    r_busy1  = 1'b0;
    r_resp   = 1'bx;
    r_tie    = 1'bx;
    r_ca     = -1;
    r_cb     = -1;
    for (int k = 1; k <= LAT + 8; k++) begin
      @(negedge clk);
      if (k == 1) r_busy1 = bus.busy;
      if (k == repulse_k) begin
        bus.start = 1'b1;
        bus.sel_a = SEL_W'($urandom_range(0, NUM_RO - 1));
        bus.sel_b = SEL_W'($urandom_range(0, NUM_RO - 1));
      end else begin
        bus.start = 1'b0;
      end
      if (bus.resp_valid) begin
        r_nvalid++;
        if (r_lat < 0) begin
          r_lat  = k;
          r_resp = bus.resp;
          r_tie  = bus.tie;
`ifdef RO_PUF_COUNT_OUT_EN
          r_ca   = int'(bus.count_a);
          r_cb   = int'(bus.count_b);
`endif
        end
      end
    end
    r_resp_end = bus.resp;
    r_tie_end  = bus.tie;
    r_busy_end = bus.busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.busy, bus.resp_valid, bus.resp, bus.tie} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in: busy/valid/resp/tie got %b want 0000",
               {bus.busy, bus.resp_valid, bus.resp, bus.tie});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.resp_valid, bus.resp, bus.tie} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_out: busy/valid/resp/tie got %b want 0000",
               {bus.busy, bus.resp_valid, bus.resp, bus.tie});
    end
`ifdef RO_PUF_COUNT_OUT_EN
    checks++;
    if (bus.count_a !== '0 || bus.count_b !== '0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.count_a, bus.count_b);
    end
`endif
  endtask

  task automatic test_challenge(input string name, input int a, input int b,
                                input int repulse_k);
    int ca, cb;
    logic exp_resp, exp_tie;
    ca = exp_count(a);
    cb = exp_count(b);
    exp_resp = (ca > cb);
    exp_tie  = (ca == cb);
    launch(a, b);
    observe(repulse_k);
    checks++;
    if (r_busy1 !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_rise: got %b want 1", name, r_busy1);
    end
    checks++;
    if (r_lat !== LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, r_lat, LAT);
    end
    checks++;
    if (r_nvalid !== 1) begin
      errors++;
      $display("FAIL %s valid_pulses: got %0d want 1", name, r_nvalid);
    end
    checks++;
    if (r_resp !== exp_resp || r_tie !== exp_tie) begin
      errors++;
      $display("FAIL %s resp/tie: got %b/%b want %b/%b (a=%0d b=%0d counts %0d/%0d)",
               name, r_resp, r_tie, exp_resp, exp_tie, a, b, ca, cb);
    end
    checks++;
    if (r_resp_end !== exp_resp || r_tie_end !== exp_tie || r_busy_end !== 1'b0) begin
      errors++;
      $display("FAIL %s hold: resp/tie/busy got %b/%b/%b want %b/%b/0",
               name, r_resp_end, r_tie_end, r_busy_end, exp_resp, exp_tie);
    end
`ifdef RO_PUF_COUNT_OUT_EN
    checks++;
    if (r_ca !== ca || r_cb !== cb) begin
      errors++;
      $display("FAIL %s counts: got %0d/%0d want %0d/%0d", name, r_ca, r_cb, ca, cb);
    end
`endif
  endtask

  task automatic test_reset_abort();
    int nvalid, nbusy;
    launch(0, 5);
    repeat (2000) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.resp_valid, bus.resp, bus.tie} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_reset: busy/valid/resp/tie got %b want 0000",
               {bus.busy, bus.resp_valid, bus.resp, bus.tie});
    end
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    nbusy  = 0;
    for (int k = 0; k < LAT + 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid) nvalid++;
      if (bus.busy) nbusy++;
    end
    checks++;
    if (nvalid !== 0 || nbusy !== 0) begin
      errors++;
      $display("FAIL abort_quiet: valid/busy cycles got %0d/%0d want 0/0", nvalid, nbusy);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sel_a = '0;
    bus.sel_b = '0;
    test_reset();
    test_challenge("ch_0_5", 0, 5, 0);
    saved_ca = r_ca;
    saved_cb = r_cb;
    test_challenge("ch_5_0", 5, 0, 0);
`ifdef RO_PUF_COUNT_OUT_EN
    checks++;
    if (r_ca !== saved_cb || r_cb !== saved_ca) begin
      errors++;
      $display("FAIL swap_counts: got %0d/%0d want %0d/%0d", r_ca, r_cb, saved_cb, saved_ca);
    end
`endif
    test_challenge("ch_7_7", 7, 7, 0);
    test_challenge("restart_ignored", 0, 5, 100);
    test_reset_abort();
    test_challenge("after_abort", 0, 5, 0);
`ifdef RO_PUF_COUNT_OUT_EN
    checks++;
    if (r_ca !== saved_ca || r_cb !== saved_cb) begin
      errors++;
      $display("FAIL repro_counts: got %0d/%0d want %0d/%0d", r_ca, r_cb, saved_ca, saved_cb);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      test_challenge("random", int'($urandom_range(0, NUM_RO - 1)),
                     int'($urandom_range(0, NUM_RO - 1)), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
